edge_capture: RTL and testbench
===============================

Name: edge_capture

Overview:
- Multi-channel, parametrised edge detector with per-channel edge-mode select, sticky event flags, saturating event counters and a combined interrupt.
- Next generation of the single-bit edge detector and set/clear flag pair.
- Sits between slow control/status inputs (buttons, done strobes, handshake lines) and the datapath/CPU-visible status logic.

Parameters:
- N_CH, 4, number of independent input channels (1..32).
- CNT_W, 8, width of each per-channel saturating event counter (1..16).

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- clk_en  input  1  clock enable; gates all sampling and state updates except reset
- in  input  N_CH  monitored input lines, synchronous to clk
- mode  input  2*N_CH  per-channel edge mode, channel i at bits [2i+1:2i], type edge_mode_e
- clr  input  N_CH  per-channel flag/counter clear request
- ien  input  N_CH  per-channel interrupt enable mask
- pulse  output  N_CH  registered one-clk event strobe per channel
- flag  output  N_CH  sticky event flag per channel
- count  output  N_CH*CNT_W  per-channel event counter, channel i at bits [(i+1)*CNT_W-1 : i*CNT_W]
- irq  output  1  OR of (flag & ien)

Interface (already decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset (rst=1 at posedge, regardless of clk_en): prev, pulse, flag and count all go to 0, so irq=0. rst has priority over every other input.
- Sampling at posedge with clk_en=1, per channel i:
  - ev = (mode=RISE & ~prev & in) | (mode=FALL & prev & ~in) | (mode=BOTH & prev^in); mode=OFF gives ev=0.
  - prev <= in, always, whatever the mode. A mode change therefore never creates a spurious event.
- pulse[i] <= clk_en ? ev : 0.
  - High for exactly one clk cycle, starting the cycle after the sampling edge (latency 1).
  - Forced low during clk_en=0 cycles.
- flag[i], updated only when clk_en=1:
  - ev=1 sets it.
  - clr=1 with ev=0 clears it.
  - ev and clr together: flag stays 1 (set wins).
  - Otherwise it holds.
- count[i], updated only when clk_en=1:
  - clr=1 and ev=1: count=1.
  - clr=1 and ev=0: count=0.
  - ev=1 only: count+1, saturating at 2^CNT_W-1 (no wrap).
  - Otherwise it holds.
- clr is ignored when clk_en=0.
- irq is combinational from registered flag and ien: irq = |(flag & ien). A change to ien alone takes effect in the same cycle.
- After reset prev=0, so an input already high at the first enabled sample registers a rising edge. This is intended.
- Reset mid-event: a pending pulse is dropped, and no event is recorded for the cycle in which rst=1.
- Input changes during clk_en=0 are not seen individually. The next enabled sample compares against the last enabled sample only.

Optional Feature:
- Macro EDGE_CAPTURE_SYNC_EN.
- When defined:
  - A 2-FF synchroniser per channel on in, clocked every clk (not gated by clk_en) and reset to 0.
  - Detection uses the synchronised value, so latency from an input change to pulse is 3 clk with clk_en held at 1.
- When undefined: in feeds detection directly, latency 1 as above.

Decomposition:
- Package gcd_pack holds:
  - typedef enum logic [1:0] edge_mode_e {EDGE_OFF=0, EDGE_RISE=1, EDGE_FALL=2, EDGE_BOTH=3};
  - localparam EDGE_CNT_W_MAX = 16.
- Sub-module edge_capture_ch implements one channel (sync, prev, pulse, flag, counter). It is instantiated N_CH times in a generate loop. The top level holds only the port slicing and the irq reduction.

Test Plan:
- Reset and first sample: rst=1 for 2 cycles with in=4'b0101 and mode=all RISE, then release with clk_en=1. Required: one-cycle pulse=4'b0101, flag=4'b0101, count ch0=ch2=1, others 0.
- Modes: ch0 RISE, ch1 FALL, ch2 BOTH, ch3 OFF; drive 0→1→0 on all channels. Required: counts 1/1/2/0, and each pulse lands 1 cycle after its transition.
- Simultaneous set/clear: hold clr[0]=1 in the same cycle as a rising edge on ch0. Required: flag[0]=1 and count[0]=1. With clr only the next cycle: flag[0]=0, count[0]=0.
- Saturation: with CNT_W=3, apply 10 rising edges on ch1. Required: count[1] stops at 7, and pulse still fires on all 10 edges.
- clk_en and irq: toggle in[2] while clk_en=0. Required: no pulse and no flag change; clr is also ignored. With ien=4'b0100, a ch2 event raises irq in the cycle flag[2] sets, and irq drops the same cycle ien[2] is deasserted.
- SYNC build (EDGE_CAPTURE_SYNC_EN defined): a rising edge on in[0] at cycle t gives pulse[0] at cycle t+3. A single-cycle glitch shorter than one clk period with clk_en=1 still counts once when it is sampled.

Source files
------------

// File: rtl/edge_capture_pkg.sv
// Shared types and limits for the edge_capture block.
package gcd_pack;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_mode_e;

    localparam int unsigned EDGE_CNT_W_MAX = 16;

endpackage

// File: rtl/edge_capture_if.sv
// Control/status bundle between the edge_capture block and its user.
interface edge_capture_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 8
);
    logic                    clk_en;
    logic [N_CH-1:0]         in;
    logic [2*N_CH-1:0]       mode;
    logic [N_CH-1:0]         clr;
    logic [N_CH-1:0]         ien;
    logic [N_CH-1:0]         pulse;
    logic [N_CH-1:0]         flag;
    logic [N_CH*CNT_W-1:0]   count;
    logic                    irq;

    modport master (
        output clk_en, in, mode, clr, ien,
        input  pulse, flag, count, irq
    );

    modport slave (
        input  clk_en, in, mode, clr, ien,
        output pulse, flag, count, irq
    );
endinterface

// File: rtl/edge_capture_ch.sv
// One edge-capture channel: optional input synchroniser, previous-sample
// register, event strobe, sticky flag and saturating counter.
// Optional: EDGE_CAPTURE_SYNC_EN adds a 2-FF synchroniser on in_i.
module edge_capture_ch
    import gcd_pack::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clk_en_i,
    input  logic             in_i,
    input  edge_mode_e       mode_i,
    input  logic             clr_i,
    output logic             pulse_o,
    output logic             flag_o,
    output logic [CNT_W-1:0] count_o
);

    logic det;

`ifdef EDGE_CAPTURE_SYNC_EN
    logic [1:0] sync_q, sync_d;

    // Synchroniser shift, runs every clock regardless of clk_en.
    always_comb begin
        sync_d = {sync_q[0], in_i};
    end

    // Synchroniser register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign det = sync_q[1];
`else
    assign det = in_i;
`endif

    logic             prev_q, prev_d;
    logic             pulse_q, pulse_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ev;

    // Edge detect against the last enabled sample.
    always_comb begin
        ev = 1'b0;
        unique case (mode_i)
            EDGE_RISE: ev = ~prev_q & det;
            EDGE_FALL: ev = prev_q & ~det;
            EDGE_BOTH: ev = prev_q ^ det;
            default:   ev = 1'b0;
        endcase
    end

    // Next-state: everything holds unless clk_en; pulse drops when disabled.
    always_comb begin
        prev_d  = prev_q;
        pulse_d = 1'b0;
        flag_d  = flag_q;
        cnt_d   = cnt_q;
        if (clk_en_i) begin
            prev_d  = det;
            pulse_d = ev;
            if (ev) begin
                flag_d = 1'b1;
            end else if (clr_i) begin
                flag_d = 1'b0;
            end
            if (clr_i) begin
                cnt_d = ev ? CNT_W'(1) : '0;
            end else if (ev && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;
    assign flag_o  = flag_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/edge_capture.sv
// Multi-channel edge capture: per-channel slicing plus the combined irq.
// Optional: EDGE_CAPTURE_SYNC_EN (handled inside edge_capture_ch).
module edge_capture
    import gcd_pack::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic          clk,
    input logic          rst,
    edge_capture_if.slave bus
);

    if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
        $error("edge_capture: N_CH out of range");
    end
    if (CNT_W < 1 || CNT_W > EDGE_CNT_W_MAX) begin : g_bad_cnt_w
        $error("edge_capture: CNT_W out of range");
    end

    logic [N_CH-1:0]       pulse_w;
    logic [N_CH-1:0]       flag_w;
    logic [N_CH*CNT_W-1:0] count_w;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_capture_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i    (clk),
            .rst_i    (rst),
            .clk_en_i (bus.clk_en),
            .in_i     (bus.in[i]),
            .mode_i   (edge_mode_e'(bus.mode[2*i +: 2])),
            .clr_i    (bus.clr[i]),
            .pulse_o  (pulse_w[i]),
            .flag_o   (flag_w[i]),
            .count_o  (count_w[i*CNT_W +: CNT_W])
        );
    end

    assign bus.pulse = pulse_w;
    assign bus.flag  = flag_w;
    assign bus.count = count_w;

    // ien acts combinationally on the registered flags.
    always_comb begin
        bus.irq = |(flag_w & bus.ien);
    end

endmodule

// File: tb/tb_edge_capture.sv
// Self-checking bench for edge_capture: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_edge_capture;
    localparam int N = 4;
    localparam int W = 3;
    localparam int CMAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    edge_capture_if #(.N_CH(N), .CNT_W(W)) bus ();

    edge_capture #(.N_CH(N), .CNT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state.
    logic [N-1:0] m_prev, m_pulse, m_flag, m_s1, m_s2;
    int           m_cnt [N];

    typedef struct {
        logic             r;
        logic             en;
        logic [N-1:0]     in;
        logic [2*N-1:0]   mode;
        logic [N-1:0]     clr;
        logic [N-1:0]     ien;
        logic [N-1:0]     e_pulse;
        logic [N-1:0]     e_flag;
        logic [N*W-1:0]   e_count;
        logic             e_irq;
    } vec_t;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clk();
        logic [N-1:0] det;
        logic         ev;
`ifdef EDGE_CAPTURE_SYNC_EN
        det = m_s2;
        m_s2 = rst ? '0 : m_s1;
        m_s1 = rst ? '0 : bus.in;
`else
        det = bus.in;
`endif
        if (rst) begin
            m_prev = '0; m_pulse = '0; m_flag = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (!bus.clk_en) begin
            m_pulse = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                case (bus.mode[2*i +: 2])
                    2'd1:    ev = !m_prev[i] && det[i];
                    2'd2:    ev = m_prev[i] && !det[i];
                    2'd3:    ev = m_prev[i] != det[i];
                    default: ev = 1'b0;
                endcase
                m_pulse[i] = ev;
                if (ev) m_flag[i] = 1'b1;
                else if (bus.clr[i]) m_flag[i] = 1'b0;
                if (bus.clr[i]) m_cnt[i] = ev ? 1 : 0;
                else if (ev) m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
                m_prev[i] = det[i];
            end
        end
    endfunction

    function automatic void model_check();
        chk("model_pulse", 32'(bus.pulse), 32'(m_pulse));
        chk("model_flag", 32'(bus.flag), 32'(m_flag));
        chk("model_irq", 32'(bus.irq), 32'(|(m_flag & bus.ien)));
        for (int i = 0; i < N; i++)
            chk($sformatf("model_count%0d", i), 32'(bus.count[i*W +: W]), 32'(m_cnt[i]));
    endfunction

    task automatic apply(input logic r, input logic en, input logic [N-1:0] i_in,
                         input logic [2*N-1:0] m, input logic [N-1:0] c,
                         input logic [N-1:0] ie);
        @(negedge clk);
        rst = r; bus.clk_en = en; bus.in = i_in; bus.mode = m; bus.clr = c; bus.ien = ie;
        @(posedge clk);
        model_clk();
        #1;
        model_check();
    endtask

    localparam logic [2*N-1:0] ALL_RISE = 8'b01010101;
    localparam logic [2*N-1:0] MIXED    = 8'b00111001;  // ch3 OFF, ch2 BOTH, ch1 FALL, ch0 RISE

    vec_t tbl [10];
    int   npulse;

    initial begin
        rst = 1'b1; bus.clk_en = 1'b0; bus.in = '0; bus.mode = '0; bus.clr = '0; bus.ien = '0;
        m_prev = '0; m_pulse = '0; m_flag = '0; m_s1 = '0; m_s2 = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;

        tbl[0] = '{1, 1, 4'b0101, ALL_RISE, 0, 0, 4'b0000, 4'b0000, 12'h000, 0};
        tbl[1] = '{1, 1, 4'b0101, ALL_RISE, 0, 0, 4'b0000, 4'b0000, 12'h000, 0};
        tbl[2] = '{0, 1, 4'b0101, ALL_RISE, 0, 0, 4'b0101, 4'b0101, 12'h041, 0};
        tbl[3] = '{0, 1, 4'b0101, ALL_RISE, 0, 0, 4'b0000, 4'b0101, 12'h041, 0};
        tbl[4] = '{1, 1, 4'b0000, MIXED,    0, 0, 4'b0000, 4'b0000, 12'h000, 0};
        tbl[5] = '{0, 1, 4'b0000, MIXED,    0, 0, 4'b0000, 4'b0000, 12'h000, 0};
        tbl[6] = '{0, 1, 4'b1111, MIXED,    0, 0, 4'b0101, 4'b0101, 12'h041, 0};
        tbl[7] = '{0, 1, 4'b0000, MIXED,    0, 0, 4'b0110, 4'b0111, 12'h089, 0};
        tbl[8] = '{0, 1, 4'b0000, MIXED,    0, 4'b0100, 4'b0000, 4'b0111, 12'h089, 1};
        tbl[9] = '{0, 1, 4'b0000, MIXED,    0, 4'b1000, 4'b0000, 4'b0111, 12'h089, 0};

`ifndef EDGE_CAPTURE_SYNC_EN
        for (int k = 0; k < 10; k++) begin
            apply(tbl[k].r, tbl[k].en, tbl[k].in, tbl[k].mode, tbl[k].clr, tbl[k].ien);
            chk($sformatf("tbl%0d_pulse", k), 32'(bus.pulse), 32'(tbl[k].e_pulse));
            chk($sformatf("tbl%0d_flag", k), 32'(bus.flag), 32'(tbl[k].e_flag));
            chk($sformatf("tbl%0d_count", k), 32'(bus.count), 32'(tbl[k].e_count));
            chk($sformatf("tbl%0d_irq", k), 32'(bus.irq), 32'(tbl[k].e_irq));
        end

        // Set wins over clear; clear alone then empties flag and counter.
        apply(1, 1, 4'b0000, ALL_RISE, 0, 0);
        apply(0, 1, 4'b0000, ALL_RISE, 0, 0);
        apply(0, 1, 4'b0001, ALL_RISE, 4'b0001, 0);
        chk("setclr_flag0", 32'(bus.flag[0]), 32'd1);
        chk("setclr_count0", 32'(bus.count[0 +: W]), 32'd1);
        apply(0, 1, 4'b0001, ALL_RISE, 4'b0001, 0);
        chk("clr_flag0", 32'(bus.flag[0]), 32'd0);
        chk("clr_count0", 32'(bus.count[0 +: W]), 32'd0);

        // Ten rising edges on ch1: counter saturates, pulse keeps firing.
        apply(1, 1, 4'b0000, ALL_RISE, 0, 0);
        npulse = 0;
        for (int k = 0; k < 10; k++) begin
            apply(0, 1, 4'b0010, ALL_RISE, 0, 0);
            if (bus.pulse[1]) npulse++;
            apply(0, 1, 4'b0000, ALL_RISE, 0, 0);
            if (bus.pulse[1]) npulse++;
        end
        chk("sat_pulses", 32'(npulse), 32'd10);
        chk("sat_count1", 32'(bus.count[W +: W]), 32'(CMAX));

        // clk_en gating and irq behaviour on ch2.
        apply(1, 1, 4'b0000, ALL_RISE, 0, 4'b0100);
        apply(0, 1, 4'b0000, ALL_RISE, 0, 4'b0100);
        apply(0, 1, 4'b0100, ALL_RISE, 0, 4'b0100);
        chk("irq_with_flag", 32'({bus.flag[2], bus.irq}), 32'b11);
        apply(0, 0, 4'b0000, ALL_RISE, 0, 4'b0100);
        apply(0, 0, 4'b0100, ALL_RISE, 4'b0100, 4'b0100);
        chk("dis_pulse", 32'(bus.pulse), 32'd0);
        apply(0, 0, 4'b0000, ALL_RISE, 4'b0100, 4'b0100);
        apply(0, 0, 4'b0100, ALL_RISE, 4'b0100, 4'b0100);
        chk("dis_clr_flag2", 32'(bus.flag[2]), 32'd1);
        chk("dis_clr_count2", 32'(bus.count[2*W +: W]), 32'd1);
        apply(0, 1, 4'b0100, ALL_RISE, 0, 4'b0100);
        chk("reen_no_event", 32'(bus.pulse[2]), 32'd0);
        @(negedge clk);
        bus.ien = 4'b0000;
        #1;
        chk("irq_ien_drop", 32'(bus.irq), 32'd0);
`else
        // Synchronised build: rise at edge t shows on pulse after edge t+2.
        apply(1, 1, 4'b0000, ALL_RISE, 0, 0);
        for (int k = 0; k < 3; k++) apply(0, 1, 4'b0000, ALL_RISE, 0, 0);
        apply(0, 1, 4'b0001, ALL_RISE, 0, 0);
        chk("sync_lat_t0", 32'(bus.pulse[0]), 32'd0);
        apply(0, 1, 4'b0001, ALL_RISE, 0, 0);
        chk("sync_lat_t1", 32'(bus.pulse[0]), 32'd0);
        apply(0, 1, 4'b0001, ALL_RISE, 0, 0);
        chk("sync_lat_t2", 32'(bus.pulse[0]), 32'd1);
        for (int k = 0; k < 3; k++) apply(0, 1, 4'b0000, ALL_RISE, 0, 0);
        apply(0, 1, 4'b0001, ALL_RISE, 0, 0);
        for (int k = 0; k < 3; k++) apply(0, 1, 4'b0000, ALL_RISE, 0, 0);
        chk("sync_glitch_count0", 32'(bus.count[0 +: W]), 32'd2);
`endif

        // Randomized traffic against the model.
        apply(1, 1, 4'b0000, 8'h00, 0, 0);
        for (int k = 0; k < 400; k++) begin
            apply(($urandom_range(0, 60) == 0), ($urandom_range(0, 4) != 0),
                  N'($urandom), (2*N)'($urandom),
                  N'($urandom & $urandom & $urandom), N'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
